// File: rtl/bullet_controller.sv
// bullet_controller
//   Per-tank bullet sequencer, advanced once per frame_clk rising edge.
//   A fire-button press launches a bullet from the tank centre along the
//   tank's facing. The bullet then moves BULLET_SPEED pixels per frame until
//   it hits a barrier, strikes the enemy tank, or would leave the play field.
//   A reload cooldown of COOLDOWN_FRAMES frames follows every despawn.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   IDLE     | no bullet; waiting for a fresh 0->1 on fire
//   FLYING   | bullet on screen, stepping along the latched dir
//   COOLDOWN | bullet despawned; reload timer counting down
//
// Ports
//   frame_clk          frame-rate clock
//   Reset              synchronous active-low reset
//   fire               fire button (level; rising edge fires)
//   dir                facing: 00 up, 01 down, 10 left, 11 right
//   TankX/TankY        own tank centre
//   EnemyX/EnemyY      enemy tank centre
//   Tank_Size          tank half-width for the hit test
//   barrier_collision  barrier checker's collision flag for this bullet
//   BulletX/BulletY    registered bullet centre
//   bullet_active      high while FLYING
//   enemy_hit          one-frame pulse on an enemy strike
//   state              00 IDLE, 01 FLYING, 10 COOLDOWN
module bullet_controller #(
  parameter int BULLET_SPEED    = 4,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       fire,
  input  logic [1:0] dir,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] Tank_Size,
  input  logic       barrier_collision,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic       bullet_active,
  output logic       enemy_hit,
  output logic [1:0] state
);

  localparam int CNT_W = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(COOLDOWN_FRAMES - 1);
  localparam logic [9:0]  SPEED10 = 10'(BULLET_SPEED);
  localparam logic [10:0] SPEED11 = 11'(BULLET_SPEED);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    FLYING   = 2'b01,
    COOLDOWN = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       bx_d, by_d;
  logic [1:0]       dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_prev_q;
  logic             hit_d;
  logic             press;
  logic [9:0]       dx, dy;
  logic             hit_test;
  logic             out_of_bounds;

  assign press = fire & ~fire_prev_q;

  // Unsigned absolute differences: subtract the smaller from the larger.
  assign dx = (BulletX >= EnemyX) ? (BulletX - EnemyX) : (EnemyX - BulletX);
  assign dy = (BulletY >= EnemyY) ? (BulletY - EnemyY) : (EnemyY - BulletY);
  assign hit_test = (dx <= Tank_Size) && (dy <= Tank_Size);

  // Bounds test on the current position, widened to 11 bits so a step past
  // either edge is caught before any 10-bit wrap can happen.
  always_comb begin
    out_of_bounds = 1'b0;
    case (dir_q)
      2'b00: out_of_bounds = {1'b0, BulletY} < (11'(Y_MIN) + SPEED11);
      2'b01: out_of_bounds = ({1'b0, BulletY} + SPEED11) > 11'(Y_MAX);
      2'b10: out_of_bounds = {1'b0, BulletX} < (11'(X_MIN) + SPEED11);
      default: out_of_bounds = ({1'b0, BulletX} + SPEED11) > 11'(X_MAX);
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state_q     <= IDLE;
      BulletX     <= 10'd0;
      BulletY     <= 10'd0;
      dir_q       <= 2'b00;
      cnt_q       <= '0;
      enemy_hit   <= 1'b0;
      fire_prev_q <= 1'b1;   // a button held through reset must not fire
    end else begin
      state_q     <= state_d;
      BulletX     <= bx_d;
      BulletY     <= by_d;
      dir_q       <= dir_d;
      cnt_q       <= cnt_d;
      enemy_hit   <= hit_d;
      fire_prev_q <= fire;
    end
  end

  always_comb begin
    state_d = state_q;
    bx_d    = BulletX;
    by_d    = BulletY;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    case (state_q)
      IDLE: begin
        bx_d = 10'd0;
        by_d = 10'd0;
        if (press) begin
          state_d = FLYING;
          bx_d    = TankX;
          by_d    = TankY;
          dir_d   = dir;
        end
      end
      FLYING: begin
        if (barrier_collision || hit_test || out_of_bounds) begin
          state_d = COOLDOWN;
          bx_d    = 10'd0;
          by_d    = 10'd0;
          cnt_d   = CNT_INIT;
          // Barrier has priority: a simultaneous enemy overlap is not a hit.
          hit_d   = ~barrier_collision & hit_test;
        end else begin
          case (dir_q)
            2'b00:   by_d = BulletY - SPEED10;
            2'b01:   by_d = BulletY + SPEED10;
            2'b10:   bx_d = BulletX - SPEED10;
            default: bx_d = BulletX + SPEED10;
          endcase
        end
      end
      COOLDOWN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bullet_active = (state_q == FLYING);
  assign state         = state_q;

endmodule

// File: tb/tb_bullet_controller.sv
module tb_bullet_controller;

  logic       frame_clk = 1'b0;
  logic       reset = 1'b0;
  logic       fire = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [9:0] tank_x = 10'd0, tank_y = 10'd0;
  logic [9:0] enemy_x = 10'd0, enemy_y = 10'd0;
  logic [9:0] tank_size = 10'd8;
  logic       barrier = 1'b0;
  logic [9:0] bullet_x, bullet_y;
  logic       bullet_active, enemy_hit;
  logic [1:0] state;

  int n_vec = 0;
  int n_err = 0;

  bullet_controller dut (
    .frame_clk(frame_clk), .Reset(reset), .fire(fire), .dir(dir),
    .TankX(tank_x), .TankY(tank_y), .EnemyX(enemy_x), .EnemyY(enemy_y),
    .Tank_Size(tank_size), .barrier_collision(barrier),
    .BulletX(bullet_x), .BulletY(bullet_y), .bullet_active(bullet_active),
    .enemy_hit(enemy_hit), .state(state)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 flying, 2 cooldown; plain signed arithmetic.
  int m_mode = 0, m_x = 0, m_y = 0, m_dir = 0, m_left = 0;
  bit m_prev = 1'b1, m_hit = 1'b0;

  task automatic model_step();
    int nx, ny, ax, ay;
    bit pressed;
    if (!reset) begin
      m_mode = 0; m_x = 0; m_y = 0; m_left = 0; m_prev = 1'b1; m_hit = 1'b0;
      return;
    end
    pressed = fire && !m_prev;
    m_prev  = fire;
    m_hit   = 1'b0;
    case (m_mode)
      0: if (pressed) begin
        m_mode = 1; m_x = int'(tank_x); m_y = int'(tank_y); m_dir = int'(dir);
      end
      1: begin
        ax = m_x - int'(enemy_x); if (ax < 0) ax = -ax;
        ay = m_y - int'(enemy_y); if (ay < 0) ay = -ay;
        nx = m_x; ny = m_y;
        case (m_dir)
          0: ny = m_y - 4;
          1: ny = m_y + 4;
          2: nx = m_x - 4;
          default: nx = m_x + 4;
        endcase
        if (barrier || (ax <= int'(tank_size) && ay <= int'(tank_size)) ||
            nx < 0 || nx > 639 || ny < 0 || ny > 479) begin
          m_hit  = !barrier && (ax <= int'(tank_size) && ay <= int'(tank_size));
          m_mode = 2; m_x = 0; m_y = 0; m_left = 30;
        end else begin
          m_x = nx; m_y = ny;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    chk("state", state, m_mode);
    chk("bullet_x", bullet_x, m_x);
    chk("bullet_y", bullet_y, m_y);
    chk("bullet_active", bullet_active, m_mode == 1);
    chk("enemy_hit", enemy_hit, m_hit);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset, then the first shot to the right.
    reset = 1'b0; fire = 1'b1;
    ticks(2);
    chk("reset_state", state, 0);
    chk("reset_x", bullet_x, 0);
    reset = 1'b1; tank_x = 10'd100; tank_y = 10'd200; dir = 2'b11;
    enemy_x = 10'd600; enemy_y = 10'd50; tank_size = 10'd8;
    tick();
    chk("held_through_reset", state, 0);
    fire = 1'b0; tick();
    fire = 1'b1; tick();
    chk("fire_state", state, 1);
    chk("fire_x", bullet_x, 100);
    chk("fire_y", bullet_y, 200);
    ticks(3);
    chk("step_x", bullet_x, 112);
    ticks(47);
    chk("pre_barrier_x", bullet_x, 300);

    // Barrier despawn and cooldown length.
    barrier = 1'b1; tick();
    barrier = 1'b0;
    chk("barrier_state", state, 2);
    chk("barrier_x", bullet_x, 0);
    ticks(29);
    chk("cooldown_29", state, 2);
    tick();
    chk("cooldown_30", state, 0);

    // Enemy hit at distance exactly Tank_Size.
    fire = 1'b0; tank_x = 10'd200; tank_y = 10'd240;
    enemy_x = 10'd320; enemy_y = 10'd240;
    tick();
    fire = 1'b1; tick();
    ticks(28);
    chk("hit_pos_x", bullet_x, 312);
    tick();
    chk("hit_pulse", enemy_hit, 1);
    chk("hit_state", state, 2);
    tick();
    chk("hit_clear", enemy_hit, 0);
    ticks(30);

    // Upward shot near the top edge: no wrap.
    fire = 1'b0; tank_x = 10'd50; tank_y = 10'd6; dir = 2'b00;
    enemy_x = 10'd600; enemy_y = 10'd400;
    tick();
    fire = 1'b1; tick();
    chk("up_y1", bullet_y, 6);
    tick();
    chk("up_y2", bullet_y, 2);
    tick();
    chk("up_cooldown", state, 2);
    chk("up_no_wrap", bullet_y, 0);

    // Fire held through cooldown does not re-fire.
    ticks(35);
    chk("held_idle", state, 0);
    fire = 1'b0; tick();
    fire = 1'b1; dir = 2'b11; tick();
    chk("refire", state, 1);

    // Reset mid-flight with a barrier hit pending.
    barrier = 1'b1; reset = 1'b0; tick();
    chk("midreset_state", state, 0);
    chk("midreset_hit", enemy_hit, 0);
    barrier = 1'b0; reset = 1'b1; fire = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      if (i % 64 == 0) begin
        tank_x    = 10'($urandom_range(0, 639));
        tank_y    = 10'($urandom_range(0, 479));
        tank_size = 10'($urandom_range(0, 24));
        if ($urandom_range(0, 1) == 0) begin
          enemy_x = 10'($urandom_range(0, 639));
          enemy_y = tank_y;
        end else begin
          enemy_x = 10'($urandom_range(0, 639));
          enemy_y = 10'($urandom_range(0, 479));
        end
      end
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      dir     = 2'($urandom_range(0, 3));
      barrier = ($urandom_range(0, 39) == 0);
      reset   = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
